// File: rtl/out_buffer_tx_if.sv
// -----------------------------------------------------------------------------
// out_buffer_tx_if
// Groups the two handshake ports of out_buffer_tx:
//   * result write port from the compute core (i_wr_en / i_wr_data /
//     i_wr_last in, o_wr_ready out)
//   * AXI4-Stream master towards the DMA S2MM channel (m_axis_tdata /
//     m_axis_tstrb / m_axis_tlast / m_axis_tvalid out, m_axis_tready in)
// Modports:
//   master : the buffer itself (drives the stream, accepts writes)
//   slave  : the environment (core + DMA) facing the buffer
// -----------------------------------------------------------------------------
interface out_buffer_tx_if;
  logic        i_wr_en;
  logic [31:0] i_wr_data;
  logic        i_wr_last;
  logic        o_wr_ready;

  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport master (
    input  i_wr_en, i_wr_data, i_wr_last, m_axis_tready,
    output o_wr_ready, m_axis_tdata, m_axis_tstrb, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    output i_wr_en, i_wr_data, i_wr_last, m_axis_tready,
    input  o_wr_ready, m_axis_tdata, m_axis_tstrb, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/out_buffer_tx.sv
// -----------------------------------------------------------------------------
// out_buffer_tx
// Collects results from the compute core into a block-RAM buffer and, once the
// core marks its final result (or the buffer fills), streams them out as one
// tlast-terminated AXI4-Stream packet to the DMA S2MM channel.
//
// Parameters:
//   DEPTH  : buffer capacity in 32-bit words (power of two, >= 4)
//   ADDR_W : log2(DEPTH)
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   io         : out_buffer_tx_if.master (write port + AXI4-Stream master)
//   o_done     : one-cycle pulse after the tlast beat handshakes
//   o_overflow : sticky, buffer filled without a last marker; cleared when
//                the next packet starts collecting
//   leds       : {state==COLLECT, state==SEND, o_overflow, done_seen}
// Build option:
//   OUT_BUFFER_PACK_EN : when defined, each write supplies one byte
//                        (i_wr_data[7:0]); bytes are packed little-endian into
//                        words and the final beat's tstrb marks valid lanes.
// -----------------------------------------------------------------------------
module out_buffer_tx #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rstn,
  out_buffer_tx_if.master io,
  output logic            o_done,
  output logic            o_overflow,
  output logic [3:0]      leds
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND    = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  state_t          state;
  logic [ADDR_W:0] word_count;   // committed words; also the write address
  logic [ADDR_W:0] rd_ptr;       // next word to fetch from the RAM
  logic            done_seen;
  logic [3:0]      final_strb;   // tstrb carried by the tlast beat

  logic            wr_accept;
  logic            commit;       // this accepted write completes a RAM word
  logic            last_slot;    // committing now fills word DEPTH
  logic [31:0]     commit_data;
  logic [3:0]      last_strb;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     ram_q;
  logic            ram_valid;
  logic            ram_last;
  beat_t           ram_beat;
  beat_t           out_beat;
  beat_t           skid_beat;
  logic            out_valid;
  logic            skid_valid;
  logic            beat_pop;
  logic            rd_issue;
  logic [1:0]      slots_used;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  assign io.o_wr_ready = rstn && (state == IDLE || state == COLLECT) &&
                         (word_count < DEPTH_W);
  assign wr_accept     = io.i_wr_en && io.o_wr_ready;
  assign last_slot     = (word_count == DEPTH_W - 1'b1);

`ifdef OUT_BUFFER_PACK_EN
  logic [1:0]  lane;       // byte lane the next write lands in
  logic [23:0] pack_buf;   // lanes 0..2 of the word being assembled
  logic [23:0] unused_hi;
  assign unused_hi = io.i_wr_data[31:8];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    commit_data = {8'h00, pack_buf} | (32'(io.i_wr_data[7:0]) << {lane, 3'b000});
    commit      = (lane == 2'd3) || io.i_wr_last;
    last_strb   = 4'hF;
    case (lane)
      2'd0:    last_strb = 4'h1;
      2'd1:    last_strb = 4'h3;
      2'd2:    last_strb = 4'h7;
      default: last_strb = 4'hF;
    endcase
  end
`else
  assign commit_data = io.i_wr_data;
  assign commit      = 1'b1;
  assign last_strb   = 4'hF;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM: collection, pointers and status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state      <= IDLE;
      word_count <= '0;
      rd_ptr     <= '0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
      done_seen  <= 1'b0;
      final_strb <= 4'h0;
`ifdef OUT_BUFFER_PACK_EN
      lane       <= 2'd0;
      pack_buf   <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (wr_accept) begin
            // The first write of a packet clears the previous overflow.
            if (state == IDLE) o_overflow <= 1'b0;
            if (commit) begin
              word_count <= word_count + 1'b1;
              final_strb <= io.i_wr_last ? last_strb : 4'hF;
            end
            if (io.i_wr_last || (commit && last_slot)) state <= SEND;
            else                                        state <= COLLECT;
            if (commit && last_slot && !io.i_wr_last) o_overflow <= 1'b1;
`ifdef OUT_BUFFER_PACK_EN
            if (commit) begin
              lane     <= 2'd0;
              pack_buf <= '0;
            end else begin
              lane     <= lane + 2'd1;
              pack_buf <= commit_data[23:0];
            end
`endif
          end
        end
        SEND: begin
          if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
          if (beat_pop && out_beat.last) begin
            state      <= IDLE;
            o_done     <= 1'b1;
            done_seen  <= 1'b1;
            word_count <= '0;
            rd_ptr     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer RAM (one write port, one registered read port)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the storage array and its read register have no reset so they map
    // onto block RAM; ram_valid below says when ram_q is meaningful.
    if (wr_accept && commit) mem[word_count[ADDR_W-1:0]] <= commit_data;
    if (rd_issue)            ram_q <= mem[rd_ptr[ADDR_W-1:0]];
  end

  // ---------------------------------------------------------------------------
  // Read-ahead and 2-entry output stage.
  // A read is issued only when the word it returns is guaranteed a slot
  // (out + skid + in-flight, minus the beat leaving this cycle, stays <= 2).
  // This keeps tvalid independent of tready and still allows one beat per
  // cycle: in steady state one word sits in out_beat and one is in flight.
  // ---------------------------------------------------------------------------
  assign beat_pop   = out_valid && io.m_axis_tready;
  assign slots_used = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, ram_valid};
  assign rd_issue   = (state == SEND) && (rd_ptr < word_count) &&
                      ((slots_used - {1'b0, beat_pop}) < 2'd2);
  assign ram_beat   = '{data: ram_q,
                        strb: ram_last ? final_strb : 4'hF,
                        last: ram_last};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ram_valid  <= 1'b0;
      ram_last   <= 1'b0;
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
    end else begin
      ram_valid <= rd_issue;
      ram_last  <= rd_issue && (rd_ptr == word_count - 1'b1);
      if (!out_valid || beat_pop) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_beat   <= skid_beat;
          skid_valid <= ram_valid;
          if (ram_valid) skid_beat <= ram_beat;
        end else begin
          out_valid <= ram_valid;
          if (ram_valid) out_beat <= ram_beat;
        end
      end else if (ram_valid) begin
        skid_valid <= 1'b1;
        skid_beat  <= ram_beat;
      end
    end
  end

  assign io.m_axis_tvalid = out_valid;
  assign io.m_axis_tdata  = out_beat.data;
  assign io.m_axis_tstrb  = out_beat.strb;
  assign io.m_axis_tlast  = out_beat.last;

  assign leds = {state == COLLECT, state == SEND, o_overflow, done_seen};

endmodule

// File: tb/tb_out_buffer_tx.sv
// -----------------------------------------------------------------------------
// tb_out_buffer_tx
// Directed sequence plus randomized packets for out_buffer_tx (DEPTH=8).
// Expected beats come from a packet-level model: the list of accepted writes
// is turned into words (one per write, or four bytes per word little-endian
// when OUT_BUFFER_PACK_EN is defined) and the last word carries tlast.
// -----------------------------------------------------------------------------
module tb_out_buffer_tx;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
`ifdef OUT_BUFFER_PACK_EN
  localparam bit PACK = 1'b1;
`else
  localparam bit PACK = 1'b0;
`endif
  // Writes accepted per packet before the buffer is full.
  localparam int CAP = PACK ? 4 * DEPTH : DEPTH;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       o_done;
  logic       o_overflow;
  logic [3:0] leds;

  out_buffer_tx_if bus ();

  out_buffer_tx #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .io         (bus),
    .o_done     (o_done),
    .o_overflow (o_overflow),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] stim_q[$];
  logic [31:0] acc_q[$];
  beat_t       exp_q[$];
  bit          pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packet model: accepted writes -> expected beats.
  task automatic build_expected();
    int n;
    int nb;
    int cnt;
    logic [31:0] w;
    n = acc_q.size();
    exp_q.delete();
    if (!PACK) begin
      for (int i = 0; i < n; i++)
        exp_q.push_back('{data: acc_q[i], strb: 4'hF, last: (i == n - 1)});
    end else begin
      nb = (n + 3) / 4;
      for (int b = 0; b < nb; b++) begin
        w   = '0;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
          if (4 * b + k < n) begin
            w[8*k +: 8] = acc_q[4*b+k][7:0];
            cnt++;
          end
        end
        exp_q.push_back('{data: w, strb: 4'((1 << cnt) - 1), last: (b == nb - 1)});
      end
    end
  endtask

  // Offers every stim_q entry once; last marker on the final one if asked.
  task automatic write_pkt(input bit with_last, input string tag);
    int n;
    bit exp_ready;
    n = stim_q.size();
    acc_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_ready        = (acc_q.size() < CAP);
      bus.i_wr_en      = 1'b1;
      bus.i_wr_data    = stim_q[i];
      bus.i_wr_last    = with_last && (i == n - 1);
      check({tag, "_wr_ready"}, 32'(bus.o_wr_ready), 32'(exp_ready));
      if (exp_ready) acc_q.push_back(stim_q[i]);
      tick();
    end
    bus.i_wr_en   = 1'b0;
    bus.i_wr_last = 1'b0;
    bus.i_wr_data = '0;
    build_expected();
  endtask

  // mode 0: tready=1, 1: fixed pattern, 2: random.  max_beats=0 -> whole packet.
  task automatic recv_pkt(input int mode, input int max_beats, input bit check_lat,
                          input string tag);
    int    cyc;
    int    first;
    int    beats;
    int    bubbles;
    bit    got_last;
    bit    stall;
    bit    rdy;
    beat_t held;
    beat_t e;
    cyc = 0; first = -1; beats = 0; bubbles = 0;
    got_last = 1'b0; stall = 1'b0; held = '0;
    while (!got_last && cyc < 400 && !(max_beats > 0 && beats >= max_beats)) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 7];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.m_axis_tready = rdy;
      if (stall) begin
        check({tag, "_hold_valid"}, 32'(bus.m_axis_tvalid), 1);
        check({tag, "_hold_data"}, bus.m_axis_tdata, held.data);
        check({tag, "_hold_ctl"}, 32'({bus.m_axis_tstrb, bus.m_axis_tlast}),
              32'({held.strb, held.last}));
      end
      if (bus.m_axis_tvalid && first < 0) first = cyc;
      if (first >= 0 && !bus.m_axis_tvalid) bubbles++;
      if (bus.m_axis_tvalid && rdy) begin
        check({tag, "_beat_expected"}, 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, "_tdata"}, bus.m_axis_tdata, e.data);
          check({tag, "_tstrb"}, 32'(bus.m_axis_tstrb), 32'(e.strb));
          check({tag, "_tlast"}, 32'(bus.m_axis_tlast), 32'(e.last));
        end
        beats++;
        got_last = bus.m_axis_tlast;
      end
      stall = bus.m_axis_tvalid && !rdy;
      held  = '{data: bus.m_axis_tdata, strb: bus.m_axis_tstrb, last: bus.m_axis_tlast};
      cyc++;
      tick();
    end
    bus.m_axis_tready = 1'b0;
    if (check_lat) check({tag, "_first_valid_cycle"}, 32'(first), 2);
    if (mode == 0) check({tag, "_bubbles"}, 32'(bubbles), 0);
    if (max_beats == 0) begin
      check({tag, "_completed"}, 32'(got_last), 1);
      check({tag, "_beats_left"}, 32'(exp_q.size()), 0);
      check({tag, "_done_pulse"}, 32'(o_done), 1);
      tick();
      check({tag, "_done_low"}, 32'(o_done), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(bus.m_axis_tvalid), 0);
    check({tag, "_tlast"}, 32'(bus.m_axis_tlast), 0);
    check({tag, "_tdata"}, bus.m_axis_tdata, 0);
    check({tag, "_tstrb"}, 32'(bus.m_axis_tstrb), 0);
    check({tag, "_done"}, 32'(o_done), 0);
    check({tag, "_overflow"}, 32'(o_overflow), 0);
    check({tag, "_leds"}, 32'(leds), 0);
    check({tag, "_wr_ready"}, 32'(bus.o_wr_ready), 0);
  endtask

  task automatic random_stim(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back($urandom);
  endtask

  initial begin
    bus.i_wr_en       = 1'b0;
    bus.i_wr_data     = '0;
    bus.i_wr_last     = 1'b0;
    bus.m_axis_tready = 1'b0;

    // Reset state
    rstn = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    #1;
    check("reset_release_ready", 32'(bus.o_wr_ready), 1);
    tick();

    // Basic transfer, tready held high
    stim_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    write_pkt(1'b1, "basic");
    recv_pkt(0, 0, 1'b1, "basic");
    check("basic_done_seen", 32'(leds[0]), 1);
    check("basic_state_idle", 32'(leds[3:2]), 0);

    // Backpressure pattern 1,0,0,1,0,1,1
    stim_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    write_pkt(1'b1, "bp");
    recv_pkt(1, 0, 1'b1, "bp");

    // Overflow: one more write than capacity, no last marker
    random_stim(CAP + 1);
    write_pkt(1'b0, "ovf");
    check("ovf_flag", 32'(o_overflow), 1);
    check("ovf_led", 32'(leds[1]), 1);
    check("ovf_state_send", 32'(leds[2]), 1);
    recv_pkt(0, 0, 1'b0, "ovf");
    check("ovf_flag_sticky", 32'(o_overflow), 1);
    random_stim(3);
    write_pkt(1'b1, "ovf_next");
    check("ovf_cleared", 32'(o_overflow), 0);
    recv_pkt(2, 0, 1'b1, "ovf_next");

    // Reset in the middle of SEND after two beats
    random_stim(PACK ? 20 : 5);
    write_pkt(1'b1, "rst");
    recv_pkt(0, 2, 1'b1, "rst");
    rstn = 1'b0;
    tick();
    check_reset_outputs("rst_mid");
    rstn = 1'b1;
    #1;
    check("rst_mid_release_ready", 32'(bus.o_wr_ready), 1);
    tick();
    exp_q.delete();
    random_stim(3);
    write_pkt(1'b1, "rst_next");
    recv_pkt(0, 0, 1'b1, "rst_next");

`ifdef OUT_BUFFER_PACK_EN
    // Byte packing with a partial final word
    stim_q = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h05, 32'h06};
    write_pkt(1'b1, "pack");
    exp_q.delete();
    exp_q.push_back('{data: 32'h04030201, strb: 4'hF, last: 1'b0});
    exp_q.push_back('{data: 32'h00000605, strb: 4'h3, last: 1'b1});
    recv_pkt(0, 0, 1'b1, "pack");
`endif

    // Single-write packet
    stim_q = '{32'hDEADBEEF};
    write_pkt(1'b1, "single");
    recv_pkt(0, 0, 1'b1, "single");
    check("single_done_seen", 32'(leds[0]), 1);

    // Randomized packets with random backpressure
    for (int p = 0; p < 6; p++) begin
      random_stim($urandom_range(1, CAP));
      write_pkt(1'b1, $sformatf("rand%0d", p));
      recv_pkt(2, 0, 1'b1, $sformatf("rand%0d", p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
